ff_d_write_arbiter: RTL
=======================

# ff_d_write_arbiter

Round-robin write arbiter for a shared W-bit D-flip-flop register. N requesters each present a request and write data. The arbiter grants one requester at a time, loads its data into the shared register and returns a one-cycle acknowledge. It sits in front of the FF_d register bank and is the only agent that drives that bank's load path.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- W, 8: shared register width.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-high reset.
- req  in  N  write request; bit i belongs to requester i.
- lock  in  N  request to keep ownership after the current write; used only when FF_ARB_LOCK_EN is defined.
- wdata  in  N*W  write data; requester i drives wdata[i*W +: W].
- gnt  out  N  one-hot grant; all zero when idle.
- ack  out  N  one-cycle pulse when requester i's write has landed in q.
- q  out  W  shared register contents.
- owner  out  $clog2(N)  index of the last requester that completed a write.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, ACK. All outputs are registered.
- Reset (clr=1, asynchronous): state=IDLE, gnt=0, ack=0, q=0, owner=0, busy=0, round-robin pointer=0 (requester 0 has highest priority).
- IDLE:
  - If req≠0, select the first set bit searching upward from the pointer, wrapping modulo N.
  - Go to GRANT and set gnt to the one-hot of the selected requester.
  - If req=0, stay in IDLE.
- GRANT (gnt[i]=1):
  - If req[i]=1: q<=wdata slice i, owner<=i, ack[i]<=1, go to ACK.
  - If req[i]=0 (withdrawal): no write, no ack, gnt<=0, pointer<=(i+1) mod N, go to IDLE.
- ACK (gnt[i]=1, ack[i]=1):
  - ack is cleared on exit.
  - Default: pointer<=(i+1) mod N, gnt<=0, go to IDLE.
  - Locked (FF_ARB_LOCK_EN defined and lock[i]=1 and req[i]=1): stay on i, go to GRANT, pointer unchanged.
- Other requesters' req changes never affect an in-progress grant.
- gnt and ack are never asserted for more than one requester at a time.
- q changes only on the edge leaving GRANT with req[i]=1, or on reset.

## Timing
- Edge numbering: req[i] high before edge E0 with the arbiter in IDLE.
  - E0: gnt[i]=1, busy=1.
  - E1: q=wdata_i (value sampled at E1), ack[i]=1.
  - E2: gnt=0, ack=0, busy=0 (unlocked case).
- Unlocked throughput is one write per 3 cycles. Locked back-to-back writes take one write per 2 cycles (ACK→GRANT→ACK).
- The requester must hold req[i] and wdata stable from assertion until it sees ack[i]=1.
- A requester that keeps req high after ack re-enters arbitration in IDLE at lowest priority.
- Wrap-around: after requester N-1 is served, the pointer becomes 0.
- clr asserted mid-operation: the FSM returns to IDLE immediately and q=0. No ack is issued for the interrupted transfer.
- Locking lets the owner hold the register indefinitely and starve other requesters. This is intended; the system enforces fairness above this block.

## Configuration
- FF_ARB_LOCK_EN defined: lock is honoured as described in ACK.
- FF_ARB_LOCK_EN undefined: the lock port still exists but is ignored. Every ACK returns to IDLE and the pointer always advances.

## Test plan
- Reset: drive clr=1 mid-run with random req/wdata -> gnt=0, ack=0, q=0, owner=0, busy=0 immediately. First grant after release goes to requester 0 when req=4'b1111.
- Single write: req=4'b0100, wdata slice 2=8'hA5 -> gnt=4'b0100 after E0; q=8'hA5, ack=4'b0100, owner=2 after E1; idle after E2.
- Round-robin: hold req=4'b1111 with distinct data for 12 cycles -> grants in order 0,1,2,3 and then wrap to 0. Each grant has exactly one ack; q follows each requester's data.
- Withdrawal: req=4'b0010 and 4'b1000, drop req[1] during GRANT -> no ack, q unchanged. Next grant is requester 3.
- Lock (macro defined): req[0]=lock[0]=1 with data 8'h11, 8'h22, 8'h33 changed after each ack, req[1]=1 -> three writes by requester 0 at 2-cycle spacing. After lock[0] drops, requester 1 is granted.
- Lock (macro undefined): same stimulus -> requesters 0 and 1 alternate, 3 cycles per write.

Source files
------------

// File: rtl/ff_d_write_arbiter.sv
// Round-robin write arbiter: grants one of N requesters and loads its W-bit data into the shared register q.
// Latency: gnt one edge after req, q/ack one edge later; 3 cycles per write, 2 per locked back-to-back write.
// Backpressure: requester holds req/wdata until ack; lock is honoured only when FF_ARB_LOCK_EN is defined.
module ff_d_write_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [W-1:0]  q_q, q_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cur_q, cur_d;
    logic          busy_q, busy_d;

    logic [IW-1:0] sel_idx;
    logic [IW-1:0] rr_idx;
    logic          sel_vld;
    logic [IW-1:0] cur_inc;
    logic [W-1:0]  cur_wdata;
    logic          cur_req;
    logic          cur_lock;
    logic          hold;

    // First requesting index at or above the pointer, wrapping modulo N.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        rr_idx  = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = IW'((int'(ptr_q) + k) % N);
            if (!sel_vld && req[rr_idx]) begin
                sel_vld = 1'b1;
                sel_idx = rr_idx;
            end
        end
    end

    always_comb begin
        cur_wdata = '0;
        cur_req   = 1'b0;
        cur_lock  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_q == IW'(i)) begin
                cur_wdata = wdata[i*W +: W];
                cur_req   = req[i];
                cur_lock  = lock[i];
            end
        end
    end

    assign cur_inc = (cur_q == IW'(N-1)) ? '0 : cur_q + 1'b1;

`ifdef FF_ARB_LOCK_EN
    assign hold = cur_lock & cur_req;
`else
    logic unused_lock;
    assign unused_lock = ^{lock, cur_lock};
    assign hold        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    cur_d   = sel_idx;
                    gnt_d   = N'(1) << sel_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (cur_req) begin
                    q_d     = cur_wdata;
                    owner_d = cur_q;
                    ack_d   = N'(1) << cur_q;
                    state_d = ACK;
                end else begin
                    // Withdrawn request: give up the slot without writing.
                    gnt_d   = '0;
                    ptr_d   = cur_inc;
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (hold) begin
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    ptr_d   = cur_inc;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    gnt_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(gnt_q));
    ack_with_gnt: assert property (@(posedge clk) disable iff (clr) (ack_q == '0) || (ack_q == gnt_q));

endmodule
